// File: rtl/instr_ram_loader.sv
// Program memory between the UART receive path and the CPU fetch port: sequential load, debug walk, multi-byte fetch.
// Optional running XOR of loaded bytes on checksum when INSTR_RAM_CHECKSUM_EN is defined.
module instr_ram_loader #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int FETCH_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          dbg_step,
    input  logic [ADDR_W-1:0]             fetch_addr,
    output logic [DATA_W-1:0]             data_out,
    output logic [ADDR_W-1:0]             dbg_addr,
    output logic [FETCH_BYTES*DATA_W-1:0] fetch_data,
    output logic                          fetch_err,
    output logic [ADDR_W:0]               fill_count,
    output logic                          full,
    output logic                          overflow,
    output logic                          busy,
    output logic [DATA_W-1:0]             checksum
);
    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic [1:0] {M_LOAD = 2'd0, M_DEBUG = 2'd1, M_FETCH = 2'd2, M_IDLE = 2'd3} mode_t;

    state_t                          state, state_next;
    mode_t                           prev_mode;
    logic [ADDR_W-1:0]               clr_idx, wr_ptr;
    logic [2:0]                      step_sync;
    logic [DATA_W-1:0]               ram [DEPTH];
    logic                            entry, wr_accept, step_edge, clr_last;
    logic [ADDR_W:0]                 dbg_addr_inc;
    logic [ADDR_W+1:0]               fsum;
    logic [FETCH_BYTES*DATA_W-1:0]   fetch_word;
    logic                            fetch_oob;

    assign full         = (fill_count == (ADDR_W+1)'(DEPTH));
    assign clr_last     = (clr_idx == ADDR_W'(DEPTH-1));
    assign dbg_addr_inc = {1'b0, dbg_addr} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        wr_ready   = 1'b0;
        entry      = 1'b0;
        wr_accept  = 1'b0;
        step_edge  = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_last) state_next = RUN;
            end
            RUN: begin
                entry     = (mode == M_LOAD) && (prev_mode != M_LOAD);
                wr_ready  = (mode == M_LOAD) && !entry && !full;
                wr_accept = wr_valid && wr_ready;
                step_edge = (mode == M_DEBUG) && step_sync[1] && !step_sync[2];
            end
            default: state_next = CLEAR;
        endcase
    end

    // Fetch indices wrap modulo DEPTH for data, but bounds are checked on the unwrapped sum.
    always_comb begin
        fetch_word = '0;
        fetch_oob  = 1'b0;
        fsum       = '0;
        for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
            fsum = {2'b00, fetch_addr} + (ADDR_W+2)'(k);
            fetch_word[k*DATA_W +: DATA_W] = ram[ADDR_W'(fsum % (ADDR_W+2)'(DEPTH))];
            if (fsum >= {1'b0, fill_count}) fetch_oob = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)  ram[clr_idx] <= '0;
            else if (wr_accept)  ram[wr_ptr]  <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx    <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
            dbg_addr   <= '0;
            data_out   <= '0;
            fetch_data <= '0;
            fetch_err  <= 1'b0;
            overflow   <= 1'b0;
            prev_mode  <= M_IDLE;
            step_sync  <= '0;
        end else begin
            step_sync <= {step_sync[1:0], dbg_step};
            if (state == CLEAR) begin
                clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
            end else begin
                prev_mode <= mode_t'(mode);
                case (mode)
                    M_LOAD: begin
                        data_out   <= '0;
                        fetch_data <= '0;
                        if (entry) begin
                            wr_ptr     <= '0;
                            fill_count <= '0;
                            overflow   <= 1'b0;
                            dbg_addr   <= '0;
                        end else if (wr_accept) begin
                            wr_ptr     <= ADDR_W'({1'b0, wr_ptr} + 1'b1);
                            fill_count <= fill_count + 1'b1;
                        end else if (wr_valid && full) begin
                            overflow <= 1'b1;
                        end
                    end
                    M_DEBUG: begin
                        data_out <= ram[dbg_addr];
                        if (step_edge)
                            dbg_addr <= (dbg_addr_inc < fill_count) ? dbg_addr_inc[ADDR_W-1:0] : '0;
                    end
                    M_FETCH: begin
                        fetch_data <= fetch_word;
                        fetch_err  <= fetch_oob;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INSTR_RAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk) begin
        if (rst)            csum <= '0;
        else if (entry)     csum <= '0;
        else if (wr_accept) csum <= csum ^ wr_data;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_ram_loader.sv
// Randomised bench for instr_ram_loader (DEPTH=8, FETCH_BYTES=2) against an array/counter model of the memory rules.
// Directed scenarios pin the model with literal expectations before the random phase.
module tb_instr_ram_loader;
    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AW = 3;
    localparam int FB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd3;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          dbg_step = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] dbg_addr;
    logic [FB*DW-1:0] fetch_data;
    logic          fetch_err;
    logic [AW:0]   fill_count;
    logic          full, overflow, busy;
    logic [DW-1:0] checksum;

    instr_ram_loader #(.DATA_W(DW), .DEPTH(DP), .FETCH_BYTES(FB)) dut (
        .clk(clk), .rst(rst), .mode(mode), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .dbg_step(dbg_step), .fetch_addr(fetch_addr),
        .data_out(data_out), .dbg_addr(dbg_addr), .fetch_data(fetch_data),
        .fetch_err(fetch_err), .fill_count(fill_count), .full(full),
        .overflow(overflow), .busy(busy), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state
    int        m_busy_left = DP;
    int        m_fill = 0;
    int        m_dbg = 0;
    int        m_prev = 3;
    int        m_dout = 0;
    int        m_fdata = 0;
    int        m_ferr = 0;
    int        m_ovf = 0;
    int        m_csum = 0;
    int        mem [DP];
    bit        h1 = 0, h2 = 0, h3 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit stp;
        int a;
        stp = h2 && !h3;
        h3 = h2; h2 = h1; h1 = dbg_step;
        if (rst) begin
            m_busy_left = DP; m_fill = 0; m_dbg = 0; m_prev = 3;
            m_dout = 0; m_fdata = 0; m_ferr = 0; m_ovf = 0; m_csum = 0;
            for (int i = 0; i < DP; i++) mem[i] = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else begin
            case (int'(mode))
                0: begin
                    m_dout = 0; m_fdata = 0;
                    if (m_prev != 0) begin
                        m_fill = 0; m_ovf = 0; m_csum = 0; m_dbg = 0;
                    end else if (wr_valid) begin
                        if (m_fill < DP) begin
                            mem[m_fill] = int'(wr_data);
                            m_fill++;
                            m_csum = m_csum ^ int'(wr_data);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
                1: begin
                    m_dout = mem[m_dbg];
                    if (stp) m_dbg = (m_dbg + 1 < m_fill) ? m_dbg + 1 : 0;
                end
                2: begin
                    m_fdata = 0; m_ferr = 0;
                    for (int k = 0; k < FB; k++) begin
                        a = int'(fetch_addr) + k;
                        m_fdata = m_fdata | (mem[a % DP] << (8 * k));
                        if (a >= m_fill) m_ferr = 1;
                    end
                end
                default: ;
            endcase
            m_prev = int'(mode);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy_left > 0));
            chk("wr_ready", 32'(wr_ready),
                32'(m_busy_left == 0 && mode == 2'd0 && m_prev == 0 && m_fill < DP));
            chk("fill_count", 32'(fill_count), 32'(m_fill));
            chk("full", 32'(full), 32'(m_fill == DP));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("dbg_addr", 32'(dbg_addr), 32'(m_dbg));
            chk("data_out", 32'(data_out), 32'(m_dout));
            chk("fetch_data", 32'(fetch_data), 32'(m_fdata));
            chk("fetch_err", 32'(fetch_err), 32'(m_ferr));
`ifdef INSTR_RAM_CHECKSUM_EN
            chk("checksum", 32'(checksum), 32'(m_csum));
`else
            chk("checksum", 32'(checksum), 32'd0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        chk(name, 32'(n), 32'(DP));
    endtask

    task automatic write_byte(input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic step_pulse();
        dbg_step = 1'b1;
        repeat (6) cyc();
        dbg_step = 1'b0;
        repeat (6) cyc();
    endtask

    initial begin
        for (int i = 0; i < DP; i++) mem[i] = 0;
        // Reset and clear length
        rst = 1'b1; mode = 2'd3;
        cyc();
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fill", 32'(fill_count), 32'd0);
        rst = 1'b0;
        wait_clear("busy_len");

        // Empty memory: every fetch is zero and out of bounds
        mode = 2'd2;
        for (int a = 0; a < DP; a++) begin
            fetch_addr = AW'(a);
            cyc();
            chk("empty_fetch", 32'(fetch_data), 32'h0);
            chk("empty_err", 32'(fetch_err), 32'd1);
        end

        // Full load plus one overflowing write
        mode = 2'd0;
        cyc();
        for (int i = 1; i <= DP; i++) write_byte(DW'(8'h11 * i));
        chk("load_fill", 32'(fill_count), 32'd8);
        chk("load_full", 32'(full), 32'd1);
        chk("load_ready", 32'(wr_ready), 32'd0);
        write_byte(8'h99);
        chk("ovf_set", 32'(overflow), 32'd1);
`ifdef INSTR_RAM_CHECKSUM_EN
        chk("csum_lit", 32'(checksum), 32'h88);
`else
        chk("csum_lit", 32'(checksum), 32'h0);
`endif

        // Fetch including wrap
        mode = 2'd2;
        fetch_addr = 3'd3; cyc();
        chk("fetch3", 32'(fetch_data), 32'h5544);
        chk("fetch3_err", 32'(fetch_err), 32'd0);
        fetch_addr = 3'd7; cyc();
        chk("fetch7", 32'(fetch_data), 32'h1188);
        chk("fetch7_err", 32'(fetch_err), 32'd1);
        fetch_addr = 3'd0; cyc();
        chk("fetch0", 32'(fetch_data), 32'h2211);

        // Debug walk over three bytes
        mode = 2'd0; cyc();
        write_byte(8'hA1); write_byte(8'hB2); write_byte(8'hC3);
        mode = 2'd1; cyc();
        chk("dbg0", 32'(data_out), 32'hA1);
        step_pulse(); chk("dbg1", 32'(data_out), 32'hB2);
        step_pulse(); chk("dbg2", 32'(data_out), 32'hC3);
        step_pulse(); chk("dbg3", 32'(data_out), 32'hA1);

        // Reset mid-load
        mode = 2'd0; cyc();
        for (int i = 0; i < 4; i++) write_byte(DW'(8'h30 + i));
        rst = 1'b1; mode = 2'd3; cyc();
        chk("midrst_fill", 32'(fill_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_clear("busy_len2");
        mode = 2'd0; cyc();
        write_byte(8'h5A);
        mode = 2'd2; fetch_addr = 3'd0; cyc();
        chk("reload", 32'(fetch_data), 32'h005A);
        chk("reload_err", 32'(fetch_err), 32'd1);

        // Mode re-entry clears pointer, fill, overflow, debug pointer
        mode = 2'd0; cyc();
        for (int i = 0; i < DP + 1; i++) write_byte(DW'(8'hE0 + i));
        chk("reent_ovf1", 32'(overflow), 32'd1);
        mode = 2'd1; step_pulse();
        chk("reent_dbg1", 32'(dbg_addr), 32'd1);
        mode = 2'd2; cyc();
        mode = 2'd0; wr_valid = 1'b1; wr_data = 8'h77; cyc();
        chk("reent_fill", 32'(fill_count), 32'd0);
        chk("reent_ovf", 32'(overflow), 32'd0);
        chk("reent_dbg", 32'(dbg_addr), 32'd0);
        cyc();
        wr_valid = 1'b0;
        chk("reent_acc", 32'(fill_count), 32'd1);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(399) == 0);
            if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
            wr_valid = ($urandom_range(9) < 7);
            wr_data = DW'($urandom);
            fetch_addr = AW'($urandom);
            if ($urandom_range(3) == 0) dbg_step = ~dbg_step;
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_ram_loader.md
Name: instr_ram_loader

Overview:
Parametrised program-memory block between the UART receive path and the CPU fetch port.
- Bytes arriving from the UART are loaded sequentially.
- Loaded contents can be stepped through byte-by-byte for debug.
- The CPU fetches multi-byte instruction words by random access.
- Adds over the previous generation: a clear FSM with busy indication, fill tracking, a full/overflow flag, fetch bounds checking and configurable fetch width.

Parameters:
DATA_W, 8, bits per memory location
DEPTH, 64, number of locations (any value >= 2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
FETCH_BYTES, 2, locations returned per CPU fetch (1..4)

Ports:
clk  in  1  single clock for all logic (connect to the UART bit-rate clock domain)
rst  in  1  synchronous, active-high reset
mode  in  2  0=load, 1=debug read, 2=CPU fetch, 3=idle/hold
wr_data  in  DATA_W  byte to load
wr_valid  in  1  wr_data valid this cycle
wr_ready  out  1  write accepted when wr_valid && wr_ready
dbg_step  in  1  debug advance request (level; rising edge acts)
fetch_addr  in  ADDR_W  CPU fetch start address
data_out  out  DATA_W  debug read byte
dbg_addr  out  ADDR_W  current debug pointer
fetch_data  out  FETCH_BYTES*DATA_W  fetched word
fetch_err  out  1  fetch touched an unloaded location
fill_count  out  ADDR_W+1  number of loaded locations
full  out  1  fill_count == DEPTH
overflow  out  1  sticky: write attempted while full
busy  out  1  clear in progress
checksum  out  DATA_W  see Optional Feature

Behaviour:
Reset and clear:
- rst=1 (any cycle, including mid-clear) enters state CLEAR.
- Reset values: clear index=0, wr_ptr=0, fill_count=0, dbg_addr=0; data_out, fetch_data, fetch_err, overflow, checksum = 0; wr_ready=0; busy=1.
- CLEAR writes 0 to one location per cycle at index 0..DEPTH-1. busy=1 for exactly DEPTH cycles after rst deasserts, then the FSM enters RUN.
- mode is ignored while busy.
RUN, mode 0 (load):
- wr_ready = !full.
- On an accepted write: ram[wr_ptr] <= wr_data, wr_ptr++, fill_count++.
- wr_valid while full: no write, overflow <= 1, wr_ptr holds. No wrap.
- Entering mode 0 from any other mode (registered previous mode) clears wr_ptr, fill_count, overflow and checksum in that cycle; a write in that same cycle is not accepted (wr_ready=0).
- In mode 0, data_out and fetch_data are driven to 0.
RUN, mode 1 (debug):
- data_out <= ram[dbg_addr] every cycle; 1-cycle latency.
- dbg_step is synchronised by a 2-flop register; a rising edge is detected on the synchronised copy.
- On an edge: dbg_addr++ only if dbg_addr+1 < fill_count; otherwise dbg_addr wraps to 0.
- dbg_addr holds its value across mode changes except entry to mode 0, which clears it.
- wr_ready=0.
RUN, mode 2 (fetch):
- Registered, 1-cycle latency.
- Byte k of fetch_data (bits k*DATA_W +: DATA_W) = ram[(fetch_addr+k) mod DEPTH], little-endian.
- fetch_err <= 1 if any (fetch_addr+k), computed unwrapped, >= fill_count; else 0.
- wr_ready=0.
RUN, mode 3:
- All registers hold; wr_ready=0; no memory access.
Widths:
- Pointer arithmetic is done in ADDR_W+1 bits, then truncated.
- fill_count saturates at DEPTH.

Optional Feature:
- Macro INSTR_RAM_CHECKSUM_EN.
- When defined: checksum is the running XOR of every accepted write byte since last reset or entry to mode 0; updated in the same cycle as the write.
- When undefined: checksum is tied to 0 and no checksum register exists.
- The port is present in both builds.

Test Plan:
(All scenarios use DEPTH=8, FETCH_BYTES=2.)
- Reset: pulse rst 1 cycle -> busy=1 for exactly 8 cycles; afterwards mode 2 fetch of every address returns 0x0000 with fetch_err=1.
- Load: mode 0, write 0x11,0x22,...,0x88 -> fill_count=8, full=1, wr_ready=0. A 9th wr_valid -> overflow=1, ram unchanged. checksum=0x88 with macro (XOR of 0x11..0x88), 0 without.
- Debug walk: load 0xA1,0xB2,0xC3, mode 1, three dbg_step rising edges -> data_out sequence 0xA1,0xB2,0xC3,0xA1 (wrap at fill_count=3). A level held high steps only once.
- Fetch: after the full load, fetch_addr=3 -> fetch_data=0x5544, fetch_err=0 one cycle later; fetch_addr=7 -> fetch_data=0x1188 (wrap) with fetch_err=1 (unwrapped addr 8 >= fill_count).
- Reset mid-operation: assert rst after 4 loaded bytes -> fill_count=0, busy=1; after the clear, re-entering mode 0 loads from address 0.
- Mode re-entry: load 3 bytes, switch to mode 2 then back to mode 0 -> fill_count=0, overflow=0, a write held on the entry cycle is not accepted, dbg_addr=0.
